// File: rtl/qam_mapper_param.sv
// rtl/qam_mapper_param.sv - serial-bit Gray-coded QPSK/16QAM/64QAM mapper with FWFT symbol FIFO
module qam_mapper_param #(
  parameter int IQ_W       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   Bin,
  input  logic [1:0]             mode,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic signed [IQ_W-1:0] I_out,
  output logic signed [IQ_W-1:0] Q_out,
  output logic [15:0]            sym_cnt,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Gray field of k bits -> signed level (2b - (2^k - 1)) scaled by 2^(IQ_W-4)
  function automatic logic signed [IQ_W-1:0] map_axis(input logic [2:0] g, input logic [2:0] k);
    logic [2:0]             b;
    logic [2:0]             odd;
    logic signed [4:0]      l5;
    logic signed [IQ_W-1:0] lvl;
    case (k)
      3'd1: begin
        b   = {2'b00, g[0]};
        odd = 3'd1;
      end
      3'd2: begin
        b   = {1'b0, g[1], g[1] ^ g[0]};
        odd = 3'd3;
      end
      default: begin
        b   = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
        odd = 3'd7;
      end
    endcase
    l5  = $signed({1'b0, b, 1'b0}) - $signed({2'b00, odd});
    lvl = {{(IQ_W-5){l5[4]}}, l5};
    return lvl <<< (IQ_W - 4);
  endfunction

  logic [2:0]             bit_cnt;
  logic [4:0]             shift_reg;
  logic [1:0]             mode_lat;
  logic [1:0]             eff_mode;
  logic [2:0]             k;
  logic [2:0]             bps;
  logic [5:0]             asm_word;
  logic                   sym_done;
  logic [2:0]             g_i;
  logic [2:0]             g_q;
  logic signed [IQ_W-1:0] lvl_i;
  logic signed [IQ_W-1:0] lvl_q;

  logic [PTR_W:0]         wr_ptr;
  logic [PTR_W:0]         rd_ptr;
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic signed [IQ_W-1:0] mem_i [FIFO_DEPTH];
  logic signed [IQ_W-1:0] mem_q [FIFO_DEPTH];

  // Symbol assembly: pick mode for this bit, form the 6-bit word, split into I/Q Gray fields
  always_comb begin
    eff_mode = (bit_cnt == 3'd0) ? mode : mode_lat;
    case (eff_mode)
      2'b01:   k = 3'd2;
      2'b10:   k = 3'd3;
      default: k = 3'd1;
    endcase
    bps      = {k[1:0], 1'b0};
    // newest bit sits at the LSB, so the earliest bit of the symbol is the field MSB
    asm_word = {shift_reg, Bin};
    sym_done = en && ((bit_cnt + 3'd1) == bps);
    case (k)
      3'd1: begin
        g_i = {2'b00, asm_word[1]};
        g_q = {2'b00, asm_word[0]};
      end
      3'd2: begin
        g_i = {1'b0, asm_word[3:2]};
        g_q = {1'b0, asm_word[1:0]};
      end
      default: begin
        g_i = asm_word[5:3];
        g_q = asm_word[2:0];
      end
    endcase
    lvl_i = map_axis(g_i, k);
    lvl_q = map_axis(g_q, k);
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && out_ready;
  // a pop on the same edge frees the slot, so a full FIFO can still take the new symbol
  assign push  = sym_done && (!full || pop);

  assign out_valid = !empty;
  assign I_out     = empty ? '0 : mem_i[rd_ptr[PTR_W-1:0]];
  assign Q_out     = empty ? '0 : mem_q[rd_ptr[PTR_W-1:0]];

  // Bit counter, shift history and per-symbol mode latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 5'd0;
      mode_lat  <= 2'b00;
    end else if (en) begin
      shift_reg <= asm_word[4:0];
      if (bit_cnt == 3'd0) mode_lat <= mode;
      bit_cnt <= sym_done ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  // FIFO pointers, accepted-symbol counter and sticky drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sym_cnt  <= 16'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        sym_cnt <= sym_cnt + 16'd1;
      end
      if (sym_done && !push) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are only observed through valid pointers so need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr[PTR_W-1:0]] <= lvl_i;
      mem_q[wr_ptr[PTR_W-1:0]] <= lvl_q;
    end
  end

endmodule

// File: tb/tb_qam_mapper_param.sv
// tb/tb_qam_mapper_param.sv - randomized and directed check of qam_mapper_param against a queue model
module tb_qam_mapper_param;

  localparam int IQ_W       = 8;
  localparam int FIFO_DEPTH = 4;

  logic                   clk;
  logic                   reset;
  logic                   en;
  logic                   Bin;
  logic [1:0]             mode;
  logic                   out_ready;
  logic                   out_valid;
  logic signed [IQ_W-1:0] I_out;
  logic signed [IQ_W-1:0] Q_out;
  logic [15:0]            sym_cnt;
  logic                   overflow;

  int n_tests;
  int n_fail;

  int bitsq[$];
  int mq_i[$];
  int mq_q[$];
  int m_mode;
  int m_cnt;
  int m_ovf;

  qam_mapper_param #(.IQ_W(IQ_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .Bin       (Bin),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .I_out     (I_out),
    .Q_out     (Q_out),
    .sym_cnt   (sym_cnt),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int axis_level(input int g, input int k);
    int b;
    b = g ^ (g >> 1) ^ (g >> 2);
    return (2 * b - ((1 << k) - 1)) * (1 << (IQ_W - 4));
  endfunction

  task automatic model_clear();
    bitsq.delete();
    mq_i.delete();
    mq_q.delete();
    m_mode = 0;
    m_cnt  = 0;
    m_ovf  = 0;
  endtask

  task automatic model_edge();
    int k;
    int gi;
    int gq;
    if (mq_i.size() > 0 && out_ready) begin
      void'(mq_i.pop_front());
      void'(mq_q.pop_front());
      m_cnt = (m_cnt + 1) & 16'hFFFF;
    end
    if (en) begin
      if (bitsq.size() == 0) m_mode = int'(mode);
      bitsq.push_back(int'(Bin));
      k = (m_mode == 1) ? 2 : (m_mode == 2) ? 3 : 1;
      if (bitsq.size() == 2 * k) begin
        gi = 0;
        gq = 0;
        for (int j = 0; j < k; j++) begin
          gi = gi * 2 + bitsq[j];
          gq = gq * 2 + bitsq[k + j];
        end
        if (mq_i.size() < FIFO_DEPTH) begin
          mq_i.push_back(axis_level(gi, k));
          mq_q.push_back(axis_level(gq, k));
        end else begin
          m_ovf = 1;
        end
        bitsq.delete();
      end
    end
  endtask

  task automatic compare_all();
    int v;
    v = (mq_i.size() > 0) ? 1 : 0;
    check_eq("out_valid", int'(out_valid), v);
    check_eq("I_out", int'(I_out), v ? mq_i[0] : 0);
    check_eq("Q_out", int'(Q_out), v ? mq_q[0] : 0);
    check_eq("sym_cnt", int'(sym_cnt), m_cnt);
    check_eq("overflow", int'(overflow), m_ovf);
  endtask

  // one clock: compare at negedge, drive, clock the DUT and the model together
  task automatic cyc(input logic e, input logic b, input logic [1:0] m, input logic r);
    compare_all();
    en        = e;
    Bin       = b;
    mode      = m;
    out_ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_I", int'(I_out), 0);
    check_eq("rst_Q", int'(Q_out), 0);
    check_eq("rst_cnt", int'(sym_cnt), 0);
    check_eq("rst_ovf", int'(overflow), 0);
    model_clear();
    en        = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send(input int bits[$], input logic [1:0] m, input logic r);
    foreach (bits[i]) cyc(1'b1, bits[i][0], m, r);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    en = 1'b0;
    Bin = 1'b0;
    mode = 2'b00;
    out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // QPSK 1,0 with ready high
    send('{1, 0}, 2'b00, 1'b1);
    check_eq("q30_valid", int'(out_valid), 1);
    check_eq("q30_I", int'(I_out), 16);
    check_eq("q30_Q", int'(Q_out), -16);
    cyc(1'b0, 1'b0, 2'b00, 1'b1);
    check_eq("q30_cnt", int'(sym_cnt), 1);

    // 16QAM and 64QAM reference points
    send('{1, 0, 0, 1}, 2'b01, 1'b0);
    check_eq("q31_16I", int'(I_out), 48);
    check_eq("q31_16Q", int'(Q_out), -16);
    cyc(1'b0, 1'b0, 2'b00, 1'b1);
    send('{0, 0, 0, 1, 0, 0}, 2'b10, 1'b0);
    check_eq("q31_64I", int'(I_out), -112);
    check_eq("q31_64Q", int'(Q_out), 112);
    cyc(1'b0, 1'b0, 2'b00, 1'b1);

    // fill FIFO, drop fifth symbol, then drain
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 2'b00, 1'b0);
    check_eq("q32_ovf", int'(overflow), 1);
    check_eq("q32_valid", int'(out_valid), 1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 2'b00, 1'b1);
    check_eq("q32_cnt", int'(sym_cnt), 4);
    check_eq("q32_empty", int'(out_valid), 0);

    // mode change mid-symbol applies to the next symbol
    do_reset();
    cyc(1'b1, 1'b1, 2'b00, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0);
    check_eq("q33_I", int'(I_out), 16);
    check_eq("q33_Q", int'(Q_out), -16);
    send('{0, 0, 0, 1, 0}, 2'b10, 1'b0);
    cyc(1'b0, 1'b0, 2'b10, 1'b1);
    check_eq("q33_partial", int'(out_valid), 0);
    send('{0}, 2'b10, 1'b0);
    check_eq("q33_64I", int'(I_out), -112);
    check_eq("q33_64Q", int'(Q_out), 112);

    // reset mid-symbol with two symbols queued
    do_reset();
    send('{1, 1, 0, 0}, 2'b00, 1'b0);
    send('{1, 0, 1}, 2'b10, 1'b0);
    check_eq("q34_pre", int'(out_valid), 1);
    do_reset();
    send('{0, 1}, 2'b00, 1'b0);
    check_eq("q34_I", int'(I_out), -16);
    check_eq("q34_Q", int'(Q_out), 16);
    cyc(1'b0, 1'b0, 2'b00, 1'b1);
    check_eq("q34_one", int'(out_valid), 0);
    check_eq("q34_cnt", int'(sym_cnt), 1);

    // en toggling during 16QAM
    do_reset();
    cyc(1'b1, 1'b1, 2'b01, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 1'b1, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 2'b01, 1'b0);
    cyc(1'b0, 1'b0, 2'b01, 1'b0);
    check_eq("q35_wait", int'(out_valid), 0);
    cyc(1'b1, 1'b1, 2'b01, 1'b0);
    check_eq("q35_I", int'(I_out), 48);
    check_eq("q35_Q", int'(Q_out), -16);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 4));
    end
    compare_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qam_mapper_param.md
QAM_MAPPER_PARAM -- requirements
Module: qam_mapper_param

Interface
REQ-001 SHALL have parameter IQ_W, default 8, meaning signed I/Q output width (legal 6..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning output symbol FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  Bin qualifier; a bit is captured only when en=1.
REQ-006 SHALL have port Bin  input  1  serial data bit.
REQ-007 SHALL have port mode  input  2  00=QPSK, 01=16QAM, 10=64QAM, 11=treated as QPSK.
REQ-008 SHALL have port out_ready  input  1  downstream accepts a symbol.
REQ-009 SHALL have port out_valid  output  1  FIFO head holds a valid symbol.
REQ-010 SHALL have port I_out  output  IQ_W  signed in-phase amplitude of FIFO head.
REQ-011 SHALL have port Q_out  output  IQ_W  signed quadrature amplitude of FIFO head.
REQ-012 SHALL have port sym_cnt  output  16  count of symbols accepted downstream, wraps 0xFFFF->0.
REQ-013 SHALL have port overflow  output  1  sticky flag, a completed symbol was dropped.

Function
REQ-014 SHALL derive bits-per-symbol BPS from mode (2/4/6) and bits-per-axis K=BPS/2.
REQ-015 SHALL latch mode only when bit counter is 0 and en=1 (first bit of a symbol); mode changes mid-symbol take effect at the next symbol.
REQ-016 SHALL shift Bin into a 6-bit assembly register on each clk edge with en=1; en=0 holds counter and partial symbol unchanged.
REQ-017 SHALL order bits first-received-first: first K bits form the I field (first bit = MSB), next K bits form the Q field.
REQ-018 SHALL treat each field as Gray code, convert to binary index b, and compute level L = 2*b - (2^K - 1).
REQ-019 SHALL scale output as L * 2^(IQ_W-4), identical scale for all modes (IQ_W=8: QPSK +-16, 64QAM +-16..+-112).
REQ-020 SHALL write the mapped I/Q pair into the FIFO on the same edge that captures the last bit of a symbol, and reset the bit counter to 0 on that edge.
REQ-021 SHALL present FIFO head first-word-fall-through; out_valid rises the cycle after a write into an empty FIFO (latency 1 cycle from last bit edge).
REQ-022 SHALL pop one entry and increment sym_cnt on every edge with out_valid=1 and out_ready=1.
REQ-023 SHALL keep I_out/Q_out stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when FIFO is full and a symbol completes with no simultaneous pop, drop the new symbol and set overflow=1 until reset.
REQ-025 SHALL, when FIFO is full and a symbol completes on an edge with a pop, accept the new symbol without overflow.
REQ-026 SHALL, when FIFO is empty, drive I_out=0 and Q_out=0 with out_valid=0.

Reset
REQ-027 SHALL, on reset=0 at any time, immediately clear bit counter, assembly register, FIFO pointers, latched mode (QPSK), sym_cnt=0, overflow=0, out_valid=0, I_out=0, Q_out=0.
REQ-028 SHALL discard any partial symbol on reset; first bit captured after reset release starts a new symbol.
REQ-029 SHALL resume normal capture on the first rising edge after reset returns to 1.

Verification
REQ-030 QPSK, IQ_W=8, out_ready=1, bits 1,0 -> one cycle after 2nd bit: out_valid=1, I_out=+16, Q_out=-16, sym_cnt then 1.
REQ-031 16QAM, bits 1,0,0,1 -> I_out=+48, Q_out=-16; 64QAM bits 0,0,0,1,0,0 -> I_out=-112, Q_out=+112.
REQ-032 QPSK, out_ready=0, FIFO_DEPTH=4, 10 bits -> 4 symbols held, 5th dropped, overflow=1; raise out_ready -> exactly 4 pops, sym_cnt=4.
REQ-033 mode switched 00->10 after 1st bit of a QPSK symbol -> that symbol completes as QPSK after 2 bits; next symbol takes 6 bits as 64QAM.
REQ-034 reset=0 asserted after 3 of 6 bits (64QAM) with 2 symbols in FIFO -> all outputs 0 immediately; after release, 2 QPSK bits produce exactly one symbol.
REQ-035 en toggled 1/0 each cycle during 16QAM stream -> symbol mapping identical to continuous en=1, only spread over 8 cycles.
